obj_merge_fifo: RTL and testbench

Parametrised sprite-pixel FIFO for the PPU pixel pipeline. It sits between the object fetcher and the pixel mixer. Each write delivers one fetched sprite row of DEPTH lanes, and the block either loads those lanes or merges them over the pixels still queued. The pixel mixer pops one pixel per cycle. Compared with the fixed 8-deep object FIFO, this block adds:
- a selectable priority rule (OAM-index or X-then-index);
- leading-pixel skip for sprites clipped at the left edge;
- refill-on-partial-occupancy, which extends the queue back to full;
- defined simultaneous push+pop behaviour;
- a sticky underflow flag.

---
 rtl/obj_merge_fifo.sv | 126 ++++++++++++
 tb/tb_obj_merge_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/obj_merge_fifo.sv
// Sprite-pixel queue between the object fetcher and the pixel mixer.
// Each write loads a full row of DEPTH lanes, merging by sprite priority over the pixels still queued.
module obj_merge_fifo #(
  parameter int DEPTH     = 8,
  parameter int IDX_W     = 6,
  parameter int PRIO_MODE = 0,
  parameter int PIX_W     = 15 + IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DEPTH*PIX_W-1:0]   wr_data,
  input  logic [$clog2(DEPTH):0]   wr_skip,
  input  logic                     rd_en,
  output logic [PIX_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     underflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int X_LSB   = 0;
  localparam int IDX_LSB = 8;
  localparam int VLD_BIT = PIX_W - 1;

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_hd;
  logic [CW-1:0]    r_count;
  logic             r_underflow;

  logic             w_empty;
  logic             w_pop;
  logic [AW-1:0]    w_hd_nxt;
  logic [CW-1:0]    w_occ;
  logic [PIX_W-1:0] w_lane    [DEPTH];
  logic [AW-1:0]    w_pos     [DEPTH];
  logic [PIX_W-1:0] w_inc     [DEPTH];
  logic [PIX_W-1:0] w_mem_nxt [DEPTH];

  // Returns 1 when the incoming sprite pixel outranks the queued one.
  function automatic logic f_beats(input logic [IDX_W-1:0] inc_idx, input logic [7:0] inc_x,
                                   input logic [IDX_W-1:0] ex_idx,  input logic [7:0] ex_x);
    logic w_res;
    if (PRIO_MODE == 0) begin
      w_res = (inc_idx < ex_idx);
    end else begin
      w_res = (inc_x < ex_x) || ((inc_x == ex_x) && (inc_idx < ex_idx));
    end
    return w_res;
  endfunction

  assign w_empty  = (r_count == {CW{1'b0}});
  assign w_pop    = rd_en && !w_empty;
  assign w_hd_nxt = w_pop ? (r_hd + {{(AW-1){1'b0}}, 1'b1}) : r_hd;
  assign w_occ    = r_count - {{AW{1'b0}}, w_pop};

  // Shift the incoming row left by wr_skip lanes, filling the tail with transparent pixels.
  always_comb begin : p_align
    int src;
    src = 0;
    for (int j = 0; j < DEPTH; j++) begin
      src = j + int'(wr_skip);
      if (src < DEPTH) begin
        w_lane[j] = wr_data[src*PIX_W +: PIX_W];
      end else begin
        w_lane[j] = {PIX_W{1'b0}};
      end
    end
  end

  // Per physical slot: find its logical position after any pop, then load or merge.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      w_pos[s] = AW'(s) - w_hd_nxt;
      w_inc[s] = w_lane[w_pos[s]];
      if (!wr_en) begin
        w_mem_nxt[s] = r_mem[s];
      end else if ({1'b0, w_pos[s]} >= w_occ) begin
        w_mem_nxt[s] = w_inc[s];
      end else if (w_inc[s][VLD_BIT] &&
                   (!r_mem[s][VLD_BIT] ||
                    f_beats(w_inc[s][IDX_LSB +: IDX_W], w_inc[s][X_LSB +: 8],
                            r_mem[s][IDX_LSB +: IDX_W], r_mem[s][X_LSB +: 8]))) begin
        w_mem_nxt[s] = w_inc[s];
      end else begin
        w_mem_nxt[s] = r_mem[s];
      end
    end
  end

  // Slot storage; a write always refills the queue to DEPTH entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_mem[s] <= {PIX_W{1'b0}};
      end
      r_hd        <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_underflow <= 1'b0;
    end else if (flush) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_mem[s] <= {PIX_W{1'b0}};
      end
      r_hd        <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_underflow <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        r_mem[s] <= w_mem_nxt[s];
      end
      r_hd        <= w_hd_nxt;
      r_count     <= wr_en ? CW'(DEPTH) : w_occ;
      r_underflow <= r_underflow | (rd_en & w_empty);
    end
  end

  assign rd_data   = w_empty ? {PIX_W{1'b0}} : r_mem[r_hd];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = (r_count == CW'(DEPTH));
  assign underflow = r_underflow;

endmodule

// File: tb/tb_obj_merge_fifo.sv
// Randomised bench for obj_merge_fifo: two instances (index priority and X priority)
// share stimulus and are compared against a queue-based reference model.
module tb_obj_merge_fifo;

  localparam int DEPTH = 8;
  localparam int IDX_W = 6;
  localparam int PIX_W = 15 + IDX_W;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int DW    = DEPTH * PIX_W;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [CW-1:0]   wr_skip;
  logic            rd_en;

  logic [PIX_W-1:0] rd_data_0, rd_data_1;
  logic [CW-1:0]    count_0, count_1;
  logic             empty_0, empty_1, full_0, full_1, uf_0, uf_1;

  int n_total;
  int n_bad;

  logic [PIX_W-1:0] mq [2][$];
  bit               muf [2];

  obj_merge_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PRIO_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_skip(wr_skip), .rd_en(rd_en), .rd_data(rd_data_0), .count(count_0),
    .empty(empty_0), .full(full_0), .underflow(uf_0));

  obj_merge_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PRIO_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_skip(wr_skip), .rd_en(rd_en), .rd_data(rd_data_1), .count(count_1),
    .empty(empty_1), .full(full_1), .underflow(uf_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PIX_W-1:0] mkpix(input bit v, input int col, input int pal,
                                              input bit bgp, input int idx, input int x);
    return {v, 2'(col), 3'(pal), bgp, 6'(idx), 8'(x)};
  endfunction

  function automatic bit m_beats(input int mode, input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    int ai, bi, ax, bx;
    ai = int'(a[13:8]); bi = int'(b[13:8]);
    ax = int'(a[7:0]);  bx = int'(b[7:0]);
    if (mode == 0) return ai < bi;
    return (ax < bx) || (ax == bx && ai < bi);
  endfunction

  // One clock edge of the reference model for both priority modes.
  task automatic model_edge(input logic we, input logic [DW-1:0] wd, input logic [CW-1:0] sk,
                            input logic re, input logic fl);
    for (int m = 0; m < 2; m++) begin
      if (fl) begin
        mq[m] = {};
        muf[m] = 0;
      end else begin
        logic [PIX_W-1:0] nq [$];
        logic [PIX_W-1:0] ln;
        if (re && mq[m].size() == 0) muf[m] = 1;
        if (re && mq[m].size() > 0) void'(mq[m].pop_front());
        if (we) begin
          nq = {};
          for (int j = 0; j < DEPTH; j++) begin
            ln = (j + int'(sk) < DEPTH) ? wd[(j + int'(sk))*PIX_W +: PIX_W] : '0;
            if (j < mq[m].size()) begin
              if (ln[PIX_W-1] && (!mq[m][j][PIX_W-1] || m_beats(m, ln, mq[m][j])))
                nq.push_back(ln);
              else
                nq.push_back(mq[m][j]);
            end else begin
              nq.push_back(ln);
            end
          end
          mq[m] = nq;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [PIX_W-1:0] e0, e1;
    e0 = (mq[0].size() > 0) ? mq[0][0] : '0;
    e1 = (mq[1].size() > 0) ? mq[1][0] : '0;
    check_val("rd_data0", 64'(rd_data_0), 64'(e0));
    check_val("count0",   64'(count_0),   64'(mq[0].size()));
    check_val("empty0",   64'(empty_0),   64'(mq[0].size() == 0));
    check_val("full0",    64'(full_0),    64'(mq[0].size() == DEPTH));
    check_val("uf0",      64'(uf_0),      64'(muf[0]));
    check_val("rd_data1", 64'(rd_data_1), 64'(e1));
    check_val("count1",   64'(count_1),   64'(mq[1].size()));
    check_val("uf1",      64'(uf_1),      64'(muf[1]));
  endtask

  // Called at a falling edge: check, drive, advance model, run one rising edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic [CW-1:0] sk,
                      input logic re, input logic fl);
    check_outputs();
    wr_en = we; wr_data = wd; wr_skip = sk; rd_en = re; flush = fl;
    model_edge(we, wd, sk, re, fl);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [DW-1:0] uni_row(input int idx, input int x);
    logic [DW-1:0] r;
    for (int j = 0; j < DEPTH; j++) r[j*PIX_W +: PIX_W] = mkpix(1, (j % 3) + 1, j % 8, 0, idx, x);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int j = 0; j < DEPTH; j++)
      r[j*PIX_W +: PIX_W] = mkpix($urandom_range(0, 4) != 0, $urandom_range(0, 3),
                                  $urandom_range(0, 7), $urandom_range(0, 1),
                                  $urandom_range(0, 3), $urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    logic [DW-1:0] row;
    n_total = 0; n_bad = 0;
    mq[0] = {}; mq[1] = {}; muf[0] = 0; muf[1] = 0;
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; wr_skip = '0;
    @(negedge clk);
    check_val("rst_count", 64'(count_0), 64'd0);
    check_val("rst_empty", 64'(empty_0), 64'd1);
    check_val("rst_rd",    64'(rd_data_0), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full load then drain in order.
    row = uni_row(5, 0);
    step(1, row, 0, 0, 0);
    check_val("load_full", 64'(full_0), 64'd1);
    check_val("load_head", 64'(rd_data_0), 64'(mkpix(1, 1, 0, 0, 5, 0)));
    for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 0, 1, 0);

    // Merge after three pops, winning and losing index.
    step(1, uni_row(4, 30), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0);
    step(1, uni_row(2, 40), 0, 0, 0);
    check_val("merge_win0", 64'(rd_data_0[13:8]), 64'd2);
    step(1, '0, 0, 1, 1);
    step(1, uni_row(4, 30), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0);
    step(1, uni_row(9, 10), 0, 0, 0);
    check_val("merge_keep0", 64'(rd_data_0[13:8]), 64'd4);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0);

    // X-priority: lower X wins, equal X falls back to index.
    step(1, uni_row(1, 20), 0, 0, 0);
    step(1, uni_row(7, 12), 0, 0, 0);
    check_val("xprio_win1",  64'(rd_data_1[7:0]), 64'd12);
    check_val("xprio_keep0", 64'(rd_data_0[13:8]), 64'd1);
    step(0, '0, 0, 0, 1);
    step(1, uni_row(1, 20), 0, 0, 0);
    step(1, uni_row(7, 20), 0, 0, 0);
    check_val("xprio_tie1", 64'(rd_data_1[13:8]), 64'd1);
    step(0, '0, 0, 0, 1);

    // Leading skip, full skip, pop+write at count one.
    step(1, rand_row(), 3, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0);
    step(1, rand_row(), 4'(DEPTH), 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, '0, 0, 1, 0);
    step(1, rand_row(), 0, 1, 0);
    check_val("popwr_count", 64'(count_0), 64'(DEPTH));

    // Underflow sticky, cleared by flush.
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 0);
    check_val("uf_set", 64'(uf_0), 64'd1);
    step(1, rand_row(), 0, 0, 0);
    step(1, rand_row(), 1, 1, 1);
    check_val("flush_uf", 64'(uf_0), 64'd0);

    // Asynchronous reset during a write.
    step(1, rand_row(), 0, 0, 0);
    check_outputs();
    wr_en = 1'b1; row = rand_row(); wr_data = row; wr_skip = 2; rd_en = 1'b1;
    #1 reset = 1'b1;
    #1;
    check_val("arst_count", 64'(count_0), 64'd0);
    check_val("arst_rd",    64'(rd_data_1), 64'd0);
    check_val("arst_full",  64'(full_1), 64'd0);
    #1 reset = 1'b0;
    mq[0] = {}; mq[1] = {}; muf[0] = 0; muf[1] = 0;
    model_edge(1, row, 2, 1, 0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 3, rand_row(), 4'($urandom_range(0, DEPTH + 1)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
